// File: rtl/sdram_uart_pkg.sv
// Shared constants for the UART-to-SDRAM read bridge: FSM encoding,
// default command/error bytes and SDRAM address field widths.
package sdram_uart_pkg;

    localparam int BANK_W = 2;
    localparam int ROW_W  = 13;
    localparam int COL_W  = 9;
    localparam int ADDR_W = BANK_W + ROW_W + COL_W;

    localparam logic [7:0] CMD_READ_DEF = 8'h52;
    localparam logic [7:0] ERR_BYTE_DEF = 8'h45;

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_ADDR2  = 4'd1;
    localparam logic [3:0] ST_ADDR1  = 4'd2;
    localparam logic [3:0] ST_ADDR0  = 4'd3;
    localparam logic [3:0] ST_REQ    = 4'd4;
    localparam logic [3:0] ST_WAIT   = 4'd5;
    localparam logic [3:0] ST_TX_HI  = 4'd6;
    localparam logic [3:0] ST_TX_LO  = 4'd7;
    localparam logic [3:0] ST_TX_ERR = 4'd8;

    // States in which an incoming UART byte cannot be consumed.
    function automatic logic rx_is_dropped(input logic [3:0] st);
        return st inside {ST_REQ, ST_WAIT, ST_TX_HI, ST_TX_LO, ST_TX_ERR};
    endfunction

endpackage

// File: rtl/sdram_uart_bridge_rdy_edge_det.sv
// Registered rising-edge detector for the controller's data-ready flag.
module rdy_edge_det (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic level_i,
    output logic rise_o
);

    logic level_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level_i;
        end
    end

    assign rise_o = level_i & ~level_q;

endmodule

// File: rtl/sdram_uart_bridge.sv
// UART command bridge: 'R' + 3 address bytes triggers one SDRAM word read,
// whose 16-bit result (or an error byte on timeout) is sent back MSB first.
module sdram_uart_bridge
    import sdram_uart_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000,
    parameter logic [7:0]  CMD_READ       = CMD_READ_DEF,
    parameter logic [7:0]  ERR_BYTE       = ERR_BYTE_DEF
) (
    input  logic              clk_100MHz,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [ADDR_W-1:0] addr,
    output logic              rd_req,
    input  logic [15:0]       rd_data,
    input  logic              rd_ready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              err_timeout,
    output logic              rx_overrun
);

    logic [3:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rd_req_q, rd_req_d;
    logic [15:0]       hold_q, hold_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic              busy_q, busy_d;
    logic              err_timeout_q, err_timeout_d;
    logic              rx_overrun_q, rx_overrun_d;
    logic              rdy_rise;
    logic              tx_fire;

    rdy_edge_det u_rdy_edge_det (
        .clk_i   (clk_100MHz),
        .rst_ni  (rst_n),
        .level_i (rd_ready),
        .rise_o  (rdy_rise)
    );

    assign tx_fire = tx_valid_q & tx_ready;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        rd_req_d      = rd_req_q;
        hold_d        = hold_q;
        cnt_d         = cnt_q;
        tx_data_d     = tx_data_q;
        tx_valid_d    = tx_valid_q;
        err_timeout_d = 1'b0;
        rx_overrun_d  = rx_valid & rx_is_dropped(state_q);

        case (state_q)
            ST_IDLE: begin
                if (rx_valid && rx_data == CMD_READ) begin
                    state_d = ST_ADDR2;
                end
            end
            ST_ADDR2: begin
                if (rx_valid) begin
                    addr_d[23:16] = rx_data;
                    state_d       = ST_ADDR1;
                end
            end
            ST_ADDR1: begin
                if (rx_valid) begin
                    addr_d[15:8] = rx_data;
                    state_d      = ST_ADDR0;
                end
            end
            ST_ADDR0: begin
                if (rx_valid) begin
                    addr_d[7:0] = rx_data;
                    state_d     = ST_REQ;
                end
            end
            ST_REQ: begin
                rd_req_d = 1'b1;
                cnt_d    = '0;
                state_d  = ST_WAIT;
            end
            // A data-ready edge takes priority over the terminal count.
            ST_WAIT: begin
                if (rdy_rise) begin
                    hold_d     = rd_data;
                    rd_req_d   = 1'b0;
                    tx_data_d  = rd_data[15:8];
                    tx_valid_d = 1'b1;
                    state_d    = ST_TX_HI;
                end else if (cnt_q == TIMEOUT_CYCLES - 16'd1) begin
                    rd_req_d      = 1'b0;
                    err_timeout_d = 1'b1;
                    tx_data_d     = ERR_BYTE;
                    tx_valid_d    = 1'b1;
                    state_d       = ST_TX_ERR;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_TX_HI: begin
                if (tx_fire) begin
                    tx_data_d = hold_q[7:0];
                    state_d   = ST_TX_LO;
                end
            end
            ST_TX_LO, ST_TX_ERR: begin
                if (tx_fire) begin
                    tx_valid_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            rd_req_q      <= 1'b0;
            hold_q        <= '0;
            cnt_q         <= '0;
            tx_data_q     <= '0;
            tx_valid_q    <= 1'b0;
            busy_q        <= 1'b0;
            err_timeout_q <= 1'b0;
            rx_overrun_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            rd_req_q      <= rd_req_d;
            hold_q        <= hold_d;
            cnt_q         <= cnt_d;
            tx_data_q     <= tx_data_d;
            tx_valid_q    <= tx_valid_d;
            busy_q        <= busy_d;
            err_timeout_q <= err_timeout_d;
            rx_overrun_q  <= rx_overrun_d;
        end
    end

    assign addr        = addr_q;
    assign rd_req      = rd_req_q;
    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign busy        = busy_q;
    assign err_timeout = err_timeout_q;
    assign rx_overrun  = rx_overrun_q;

endmodule

// File: tb/tb_sdram_uart_bridge.sv
// Directed bench for sdram_uart_bridge with a transaction-level model:
// expected TX byte queue, expected address and per-frame event counters.
module tb_sdram_uart_bridge;

    localparam logic [15:0] TIMEOUT = 16'd16;
    localparam logic [7:0]  CMD     = 8'h52;
    localparam logic [7:0]  ERRB    = 8'h45;

    logic        clk_100MHz;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [23:0] addr;
    logic        rd_req;
    logic [15:0] rd_data;
    logic        rd_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        err_timeout;
    logic        rx_overrun;

    int nCompared = 0;
    int nMismatch = 0;

    logic [7:0]  expTx[$];
    logic [23:0] expAddr = '0;
    int          txPushed = 0;
    int          txSent = 0;
    int          rdReqCycles = 0;
    int          errCount = 0;
    int          errAtCycle = -1;
    int          overCount = 0;
    logic        prevValid = 1'b0;
    logic        prevReady = 1'b0;
    logic [7:0]  prevData = '0;

    sdram_uart_bridge #(
        .TIMEOUT_CYCLES (TIMEOUT),
        .CMD_READ       (CMD),
        .ERR_BYTE       (ERRB)
    ) dut (
        .clk_100MHz  (clk_100MHz),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .addr        (addr),
        .rd_req      (rd_req),
        .rd_data     (rd_data),
        .rd_ready    (rd_ready),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .err_timeout (err_timeout),
        .rx_overrun  (rx_overrun)
    );

    initial clk_100MHz = 1'b0;
    always #5 clk_100MHz = ~clk_100MHz;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatch++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_100MHz);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic expectData(input logic [15:0] d);
        expTx.push_back(8'(d >> 8));
        expTx.push_back(8'(d & 16'h00FF));
        txPushed += 2;
    endtask

    task automatic expectErr();
        expTx.push_back(ERRB);
        txPushed += 1;
    endtask

    task automatic sendFrame(input logic [23:0] a);
        expAddr     = a;
        txPushed    = 0;
        txSent      = 0;
        rdReqCycles = 0;
        errCount    = 0;
        errAtCycle  = -1;
        overCount   = 0;
        applyStimulus(CMD);
        applyStimulus(a[23:16]);
        applyStimulus(a[15:8]);
        applyStimulus(a[7:0]);
        for (int i = 0; i < 10 && !rd_req; i++) tick();
        checkOutput("rd_req_rise", 32'(rd_req), 32'd1);
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 100 && busy; i++) tick();
        checkOutput("busy_after_frame", 32'(busy), 32'd0);
    endtask

    task automatic endFrame(input int expErr, input int expOver);
        checkOutput("err_timeout_pulses", 32'(errCount), 32'(expErr));
        checkOutput("rx_overrun_pulses", 32'(overCount), 32'(expOver));
        checkOutput("tx_bytes_sent", 32'(txSent), 32'(txPushed));
        checkOutput("tx_queue_left", 32'(expTx.size()), 32'd0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_addr"}, 32'(addr), 32'd0);
        checkOutput({tag, "_rd_req"}, 32'(rd_req), 32'd0);
        checkOutput({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        checkOutput({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_err_timeout"}, 32'(err_timeout), 32'd0);
        checkOutput({tag, "_rx_overrun"}, 32'(rx_overrun), 32'd0);
    endtask

    // Cycle monitor: handshakes, hold-while-stalled, address stability, event counts.
    always @(negedge clk_100MHz) begin
        if (!rst_n) begin
            prevValid = 1'b0;
        end else begin
            if (prevValid && !prevReady) begin
                checkOutput("tx_valid_hold", 32'(tx_valid), 32'd1);
                checkOutput("tx_data_hold", 32'(tx_data), 32'(prevData));
            end
            if (tx_valid && tx_ready) begin
                txSent++;
                if (expTx.size() == 0) checkOutput("tx_queue_empty", 32'(expTx.size()), 32'd1);
                else checkOutput("tx_byte", 32'(tx_data), 32'(expTx.pop_front()));
            end
            if (rd_req) begin
                rdReqCycles++;
                checkOutput("addr_stable", 32'(addr), 32'(expAddr));
            end
            if (rd_req || tx_valid) checkOutput("busy_active", 32'(busy), 32'd1);
            if (err_timeout) begin
                errCount++;
                errAtCycle = rdReqCycles;
            end
            if (rx_overrun) overCount++;
            prevValid = tx_valid;
            prevReady = tx_ready;
            prevData  = tx_data;
        end
    end

    initial begin
        rst_n    = 1'b0;
        rx_data  = '0;
        rx_valid = 1'b0;
        rd_data  = '0;
        rd_ready = 1'b0;
        tx_ready = 1'b1;
        repeat (3) tick();
        checkResetOutputs("por");
        rst_n = 1'b1;
        tick();

        $display("[TB] garbage byte in IDLE");
        applyStimulus(8'h00);
        tick();
        tick();
        checkOutput("garbage_busy", 32'(busy), 32'd0);
        checkOutput("garbage_overrun", 32'(overCount), 32'd0);

        $display("[TB] normal read 012345 -> BEEF");
        sendFrame(24'h012345);
        expectData(16'hBEEF);
        repeat (6) tick();
        rd_data  = 16'hBEEF;
        rd_ready = 1'b1;
        waitIdle();
        checkOutput("a_addr", 32'(addr), 32'h012345);
        checkOutput("a_rd_req_cycles", 32'(rdReqCycles), 32'd7);
        endFrame(0, 0);

        $display("[TB] back-to-back frame, timeout path");
        rd_ready = 1'b0;
        sendFrame(24'hABCDEF);
        expectErr();
        waitIdle();
        checkOutput("to_rd_req_cycles", 32'(rdReqCycles), 32'(TIMEOUT));
        checkOutput("to_err_cycle", 32'(errAtCycle), 32'd16);
        endFrame(1, 0);

        $display("[TB] rd_ready stuck high");
        rd_ready = 1'b1;
        tick();
        sendFrame(24'h3F00AA);
        expectErr();
        waitIdle();
        endFrame(1, 0);
        rd_ready = 1'b0;
        tick();

        $display("[TB] edge on terminal count");
        sendFrame(24'h155AA5);
        expectData(16'h1234);
        repeat (15) tick();
        rd_data  = 16'h1234;
        rd_ready = 1'b1;
        waitIdle();
        checkOutput("tc_rd_req_cycles", 32'(rdReqCycles), 32'd16);
        endFrame(0, 0);
        rd_ready = 1'b0;
        tick();

        $display("[TB] backpressure and overrun");
        tx_ready = 1'b0;
        sendFrame(24'h0A0B0C);
        expectData(16'hBEEF);
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        repeat (4) tick();
        rd_data  = 16'hBEEF;
        rd_ready = 1'b1;
        for (int i = 0; i < 10 && !tx_valid; i++) tick();
        repeat (10) tick();
        checkOutput("bp_tx_valid", 32'(tx_valid), 32'd1);
        checkOutput("bp_tx_data", 32'(tx_data), 32'hBE);
        tx_ready = 1'b1;
        waitIdle();
        checkOutput("bp_rd_req_cycles", 32'(rdReqCycles), 32'd7);
        endFrame(0, 2);
        rd_ready = 1'b0;
        tick();

        $display("[TB] reset during WAIT");
        sendFrame(24'h00FACE);
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checkResetOutputs("mid_rst");
        expTx.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        sendFrame(24'hC0FFEE);
        expectData(16'hCAFE);
        repeat (2) tick();
        rd_data  = 16'hCAFE;
        rd_ready = 1'b1;
        waitIdle();
        checkOutput("post_rst_rd_req_cycles", 32'(rdReqCycles), 32'd3);
        endFrame(0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
